// File: rtl/lutram_pkg.sv
// Shared constants and read-controller state type for the 32x8 LUT RAM scratch store.
package lutram_pkg;

   localparam int RAM_AW    = 5;
   localparam int RAM_DW    = 8;
   localparam int RAM_DEPTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } rd_state_t;

endpackage

// File: rtl/lutram_32x8_model.sv
// 32x8 distributed RAM: one synchronous write port, one asynchronous read port.
module lutram_32x8_model
   import lutram_pkg::*;
(
   input  logic              WCLK,
   input  logic              WE,
   input  logic [RAM_AW-1:0] ADDRD,
   input  logic [RAM_DW-1:0] DI,
   input  logic [RAM_AW-1:0] RADDR,
   output logic [RAM_DW-1:0] RDATA
);

   logic [RAM_DW-1:0] mem [RAM_DEPTH];

   always_ff @(posedge WCLK) begin
      if (WE) begin
         mem[ADDRD] <= DI;
      end
   end

   // Read is combinational; a write in the same cycle shows up only after the edge.
   assign RDATA = mem[RADDR];

endmodule

// File: rtl/lutram_burst_reader.sv
// Walks a wrapping address range on the LUT RAM async read port and streams the
// words out on a valid/ready interface, flagging the final beat with M_LAST.
module lutram_burst_reader
   import lutram_pkg::*;
#(
   parameter int AW = RAM_AW,
   parameter int DW = RAM_DW,
   parameter int LW = 6
) (
   input  logic          WCLK,
   input  logic          RST_N,
   input  logic          START,
   input  logic [AW-1:0] BASE,
   input  logic [LW-1:0] LEN,
   output logic          BUSY,
   output logic          DONE,
   output logic [AW-1:0] RADDR,
   input  logic [DW-1:0] RDATA,
   output logic          M_VALID,
   input  logic          M_READY,
   output logic [DW-1:0] M_DATA,
   output logic          M_LAST
);

   localparam logic [LW-1:0] DEPTH = LW'(2 ** AW);

   rd_state_t     state_reg, state_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic [LW-1:0] rem_reg, rem_next;
   logic [DW-1:0] data_reg, data_next;
   logic          valid_reg, valid_next;
   logic          last_reg, last_next;
   logic          load;

   always_ff @(posedge WCLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         rem_reg   <= '0;
         data_reg  <= '0;
         valid_reg <= 1'b0;
         last_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         rem_reg   <= rem_next;
         data_reg  <= data_next;
         valid_reg <= valid_next;
         last_reg  <= last_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      rem_next   = rem_reg;
      data_next  = data_reg;
      valid_next = valid_reg;
      last_next  = last_reg;
      load       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (START) begin
               addr_next  = BASE;
               rem_next   = (LEN > DEPTH) ? DEPTH : LEN;
               state_next = (LEN == '0) ? FIN : RUN;
            end
         end
         RUN: begin
            // Refill the output register whenever it is empty or being drained.
            load = (rem_reg != '0) && (!valid_reg || M_READY);
            if (load) begin
               data_next  = RDATA;
               valid_next = 1'b1;
               last_next  = (rem_reg == LW'(1));
               addr_next  = addr_reg + 1'b1;
               rem_next   = rem_reg - 1'b1;
            end else if ((rem_reg == '0) && valid_reg && M_READY && last_reg) begin
               valid_next = 1'b0;
               last_next  = 1'b0;
               state_next = FIN;
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign BUSY    = (state_reg == RUN);
   assign DONE    = (state_reg == FIN);
   assign RADDR   = addr_reg;
   assign M_VALID = valid_reg;
   assign M_DATA  = data_reg;
   assign M_LAST  = last_reg;

endmodule

// File: tb/tb_lutram_burst_reader.sv
// Bench for lutram_burst_reader: queue-based burst model checked every cycle,
// plus literal expectations on beat contents, latency and reset behaviour.
module tb_lutram_burst_reader;
   import lutram_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [4:0] base;
   logic [5:0] len;
   logic       busy, done;
   logic [4:0] raddr;
   logic [7:0] rdata;
   logic       m_valid, m_ready, m_last;
   logic [7:0] m_data;
   logic       we;
   logic [4:0] addrd;
   logic [7:0] di;

   always #5 clk = ~clk;

   lutram_burst_reader #(.AW(5), .DW(8), .LW(6)) dut (
      .WCLK(clk), .RST_N(rst_n), .START(start), .BASE(base), .LEN(len),
      .BUSY(busy), .DONE(done), .RADDR(raddr), .RDATA(rdata),
      .M_VALID(m_valid), .M_READY(m_ready), .M_DATA(m_data), .M_LAST(m_last)
   );

   lutram_32x8_model ram (
      .WCLK(clk), .WE(we), .ADDRD(addrd), .DI(di), .RADDR(raddr), .RDATA(rdata)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Model state: RAM image (written by stimulus only) and command mailbox.
   logic [7:0] ram_m [32];
   int cmd_cnt  = 0;
   int cmd_base = 0;
   int cmd_len  = 0;

   // Owned by the compare process.
   int         cmd_seen        = 0;
   int         neg_cnt         = 0;
   int         start_t         = 0;
   int         first_valid_neg = -1;
   int         done_neg        = -1;
   bit         burst_active    = 0;
   bit         done_due        = 0;
   bit         prev_stall      = 0;
   logic [7:0] prev_data;
   logic       prev_last;
   logic [4:0] prev_raddr;
   logic [7:0] exp_q [$];
   logic [7:0] obs_log [$];
   logic       last_log [$];

   always @(negedge clk) begin : cmp
      int  n;
      bit  exp_done;
      neg_cnt++;
      if (!rst_n) begin
         exp_q.delete();
         burst_active = 0;
         done_due     = 0;
         prev_stall   = 0;
      end else begin
         exp_done = done_due;
         done_due = 0;
         if (cmd_cnt != cmd_seen) begin
            cmd_seen = cmd_cnt;
            start_t  = neg_cnt - 1;
            obs_log.delete();
            last_log.delete();
            first_valid_neg = -1;
            done_neg        = -1;
            n = (cmd_len > 32) ? 32 : cmd_len;
            for (int k = 0; k < n; k++) exp_q.push_back(ram_m[(cmd_base + k) % 32]);
            if (n == 0) exp_done = 1;
            else burst_active = 1;
         end
         chk("done", done, exp_done);
         if (done && done_neg < 0) done_neg = neg_cnt;
         chk("busy", busy, burst_active);
         if (prev_stall) begin
            chk("stall_valid", m_valid, 1'b1);
            chk("stall_data", m_data, prev_data);
            chk("stall_last", m_last, prev_last);
            chk("stall_raddr", raddr, prev_raddr);
         end
         if (exp_q.size() == 0) begin
            chk("no_extra_beat", m_valid, 1'b0);
         end else if (m_valid) begin
            if (first_valid_neg < 0) first_valid_neg = neg_cnt;
            chk("beat_data", m_data, exp_q[0]);
            chk("beat_last", m_last, exp_q.size() == 1);
            if (m_ready) begin
               $display("beat data=%02h last=%0b", m_data, m_last);
               obs_log.push_back(m_data);
               last_log.push_back(m_last);
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin
                  burst_active = 0;
                  done_due     = 1;
               end
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         prev_raddr = raddr;
      end
   end

   task automatic issue(input int b, input int l);
      @(posedge clk); #1;
      start = 1'b1;
      base  = 5'(b);
      len   = 6'(l);
      @(posedge clk); #1;
      start    = 1'b0;
      cmd_base = b;
      cmd_len  = l;
      cmd_cnt++;
      @(negedge clk); #1;
      chk("raddr_base", raddr, 32'(b));
      $display("cmd base=%0d len=%0d", b, l);
   endtask

   task automatic wait_done(input string name, input int limit);
      int k = 0;
      while (done_neg < 0 && k < limit) begin
         @(negedge clk);
         k++;
      end
      #1;
      chk({name, "_done_seen"}, (done_neg >= 0), 1'b1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_busy"}, busy, 1'b0);
      chk({name, "_done"}, done, 1'b0);
      chk({name, "_valid"}, m_valid, 1'b0);
      chk({name, "_last"}, m_last, 1'b0);
      chk({name, "_data"}, m_data, 8'h00);
      chk({name, "_raddr"}, raddr, 5'd0);
   endtask

   initial begin
      logic [5:0] pat;
      rst_n = 1'b1; start = 1'b0; base = '0; len = '0;
      m_ready = 1'b1; we = 1'b0; addrd = '0; di = '0;
      #2 rst_n = 1'b0;
      #1 chk_zero("reset");

      for (int i = 0; i < 32; i++) begin
         @(posedge clk); #1;
         we = 1'b1; addrd = 5'(i); di = 8'(8'h40 + i);
         ram_m[i] = 8'(8'h40 + i);
      end
      @(posedge clk); #1 we = 1'b0;
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Basic burst
      issue(3, 4);
      wait_done("t1", 40);
      chk("t1_count", obs_log.size(), 4);
      for (int k = 0; k < 4; k++) chk("t1_data", obs_log[k], 8'h43 + 8'(k));
      chk("t1_last", last_log[3], 1'b1);
      chk("t1_first_valid_lat", first_valid_neg - start_t, 2);
      chk("t1_done_lat", done_neg - start_t, 6);

      // Wrap 31 -> 0
      issue(30, 4);
      wait_done("t2", 40);
      chk("t2_count", obs_log.size(), 4);
      chk("t2_d0", obs_log[0], 8'h5E);
      chk("t2_d1", obs_log[1], 8'h5F);
      chk("t2_d2", obs_log[2], 8'h40);
      chk("t2_d3", obs_log[3], 8'h41);
      chk("t2_last", last_log[3], 1'b1);

      // Zero length
      issue(12, 0);
      wait_done("t3", 20);
      chk("t3_count", obs_log.size(), 0);
      chk("t3_no_valid", first_valid_neg, 32'hFFFF_FFFF);
      chk("t3_done_lat", done_neg - start_t, 1);

      // Saturating length, full depth from a non-zero base
      issue(7, 40);
      wait_done("t4", 80);
      chk("t4_count", obs_log.size(), 32);
      chk("t4_first", obs_log[0], 8'h47);
      chk("t4_last_data", obs_log[31], 8'h46);
      chk("t4_last_flag", last_log[31], 1'b1);

      // Backpressure pattern 1,0,0,1,0,1 repeating
      pat = 6'b101001;
      issue(0, 5);
      for (int k = 0; k < 40 && done_neg < 0; k++) begin
         @(posedge clk); #1;
         m_ready = pat[k % 6];
      end
      @(posedge clk); #1 m_ready = 1'b1;
      wait_done("t5", 20);
      chk("t5_count", obs_log.size(), 5);
      for (int k = 0; k < 5; k++) chk("t5_data", obs_log[k], 8'h40 + 8'(k));

      // START during a burst is ignored
      issue(20, 6);
      repeat (2) @(posedge clk); #1;
      start = 1'b1; base = 5'd10; len = 6'd3;
      @(posedge clk); #1 start = 1'b0;
      wait_done("t6", 40);
      chk("t6_count", obs_log.size(), 6);
      for (int k = 0; k < 6; k++) chk("t6_data", obs_log[k], 8'h54 + 8'(k));

      // START in the DONE cycle is ignored
      issue(5, 1);
      repeat (2) @(posedge clk); #1;
      start = 1'b1; base = 5'd9; len = 6'd2;
      @(posedge clk); #1 start = 1'b0;
      wait_done("t7", 20);
      chk("t7_done_lat", done_neg - start_t, 3);
      chk("t7_count", obs_log.size(), 1);
      chk("t7_data", obs_log[0], 8'h45);
      repeat (3) @(posedge clk); #1;
      chk("t7_idle_busy", busy, 1'b0);

      // Asynchronous reset mid-burst
      issue(0, 8);
      for (int i = 0; i < 20 && obs_log.size() < 2; i++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero("midrst");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (4) @(posedge clk); #1;
      chk("midrst_no_done", (done_neg < 0), 1'b1);
      issue(0, 1);
      wait_done("t8", 20);
      chk("t8_count", obs_log.size(), 1);
      chk("t8_data", obs_log[0], 8'h40);
      chk("t8_last", last_log[0], 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
